// File: rtl/memory_game_pkg.sv
// memory_game_pkg
// Shared constants, state encoding and helpers for the memory-game checker.
//   DISPLAY_CYCLE_DEF   : default number of stored values checked per round
//   FEEDBACK_CYCLES_DEF : default number of cycles a per-guess result stays on led
//   LED_W / ADDR_W      : width of the led/switch/memory data and of the read address
//   SCORE_W             : width of the score counter
//   state_t             : checker FSM states
//   thermometer()       : bit i high iff i < n
package memory_game_pkg;

  localparam int DISPLAY_CYCLE_DEF   = 10;
  localparam int FEEDBACK_CYCLES_DEF = 4;
  localparam int LED_W               = 10;
  localparam int ADDR_W              = 4;
  localparam int SCORE_W             = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_KEY = 3'd1,
    S_COMPARE  = 3'd2,
    S_FEEDBACK = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  function automatic logic [LED_W-1:0] thermometer(input logic [SCORE_W-1:0] n);
    logic [LED_W-1:0] t;
    t = '0;
    for (int i = 0; i < LED_W; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

endpackage

// File: rtl/game_check_if.sv
// game_check_if
// Groups the player/memory/display signals of the checker.
//   check_start : one-cycle pulse, begins (or restarts) a round
//   confirm_key : raw active-low player key, asynchronous to the clock
//   sw          : player guess switches
//   q           : memory read data, combinational function of rn
//   rn          : memory read address (current guess index)
//   led         : feedback display
//   score       : correct guesses this round
//   busy/done/pass : round status
// The master modport drives stimulus and memory data, the slave modport is the checker.
interface game_check_if;
  import memory_game_pkg::*;

  logic               check_start;
  logic               confirm_key;
  logic [LED_W-1:0]   sw;
  logic [LED_W-1:0]   q;
  logic [ADDR_W-1:0]  rn;
  logic [LED_W-1:0]   led;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               done;
  logic               pass;

  modport master (
    output check_start, confirm_key, sw, q,
    input  rn, led, score, busy, done, pass
  );

  modport slave (
    input  check_start, confirm_key, sw, q,
    output rn, led, score, busy, done, pass
  );

endinterface

// File: rtl/game_check_key_edge_sync.sv
// key_edge_sync
// Brings the raw active-low player key into the clock domain and turns each
// press into a single-cycle pulse, however long the key is held.
//   i_clk    : clock
//   i_resetn : asynchronous active-low reset
//   i_keyN   : raw active-low key
//   o_press  : one-cycle pulse on the cycle the synchronized level falls 1->0
module key_edge_sync (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_keyN,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_syncPrev;

  // Two-flop synchronizer plus one flop of history for edge detection.
  // All flops reset to 1 so a released key never looks like a press.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_syncPrev <= 1'b1;
    end else begin
      r_sync1    <= i_keyN;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
    end
  end

  assign o_press = r_syncPrev & ~r_sync2;

endmodule

// File: rtl/game_check.sv
// game_check
// Round controller of the memory game: walks through DISPLAY_CYCLE stored
// values, takes one player guess per value, shows per-guess feedback on led
// for FEEDBACK_CYCLES cycles and finally a thermometer of the score.
//   game_clk : clock, rising edge
//   resetn   : asynchronous active-low reset
//   bus      : game_check_if slave (check_start, confirm_key, sw, q in;
//              rn, led, score, busy, done, pass out)
module game_check
  import memory_game_pkg::*;
#(
  parameter int DISPLAY_CYCLE   = DISPLAY_CYCLE_DEF,
  parameter int FEEDBACK_CYCLES = FEEDBACK_CYCLES_DEF
) (
  input  logic         game_clk,
  input  logic         resetn,
  game_check_if.slave  bus
);

  state_t             r_state;
  state_t             w_nextState;

  logic [ADDR_W-1:0]  r_index;
  logic [SCORE_W-1:0] r_score;
  logic [LED_W-1:0]   r_guess;
  logic [LED_W-1:0]   r_led;
  logic [3:0]         r_fbCnt;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;

  logic [ADDR_W-1:0]  w_nextIndex;
  logic [SCORE_W-1:0] w_nextScore;
  logic [LED_W-1:0]   w_nextGuess;
  logic [LED_W-1:0]   w_nextLed;
  logic [3:0]         w_nextFbCnt;
  logic               w_nextBusy;
  logic               w_nextDone;
  logic               w_nextPass;

  logic               w_press;
  logic               w_lastIndex;
  logic               w_fbLast;

  key_edge_sync u_keySync (
    .i_clk    (game_clk),
    .i_resetn (resetn),
    .i_keyN   (bus.confirm_key),
    .o_press  (w_press)
  );

  assign w_lastIndex = (r_index == ADDR_W'(DISPLAY_CYCLE - 1));
  assign w_fbLast    = (r_fbCnt == 4'(FEEDBACK_CYCLES - 1));

  // State register.
  always_ff @(posedge game_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. check_start restarts the round from any state and
  // beats a simultaneous press.
  always_comb begin
    w_nextState = r_state;
    if (bus.check_start) begin
      w_nextState = S_WAIT_KEY;
    end else begin
      case (r_state)
        S_WAIT_KEY: if (w_press) w_nextState = S_COMPARE;
        S_COMPARE:  w_nextState = S_FEEDBACK;
        S_FEEDBACK: if (w_fbLast) w_nextState = w_lastIndex ? S_DONE : S_WAIT_KEY;
        default:    w_nextState = r_state;
      endcase
    end
  end

  // Output/datapath logic: next values of every registered output.
  // Presses outside WAIT_KEY fall through untouched and are simply lost.
  always_comb begin
    w_nextIndex = r_index;
    w_nextScore = r_score;
    w_nextGuess = r_guess;
    w_nextLed   = r_led;
    w_nextFbCnt = r_fbCnt;
    if (bus.check_start) begin
      w_nextIndex = '0;
      w_nextScore = '0;
      w_nextLed   = '0;
      w_nextFbCnt = '0;
    end else begin
      case (r_state)
        S_WAIT_KEY: begin
          if (w_press) w_nextGuess = bus.sw;
        end
        S_COMPARE: begin
          w_nextFbCnt = '0;
          if (r_guess == bus.q) begin
            if (r_score < SCORE_W'(DISPLAY_CYCLE)) w_nextScore = r_score + 1'b1;
            w_nextLed = '1;
          end else begin
            w_nextLed = bus.q;
          end
        end
        S_FEEDBACK: begin
          if (w_fbLast) begin
            if (w_lastIndex) begin
              w_nextLed = thermometer(r_score);
            end else begin
              w_nextLed   = '0;
              w_nextIndex = r_index + 1'b1;
            end
          end else begin
            w_nextFbCnt = r_fbCnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
    w_nextBusy = (w_nextState == S_WAIT_KEY) || (w_nextState == S_COMPARE) ||
                 (w_nextState == S_FEEDBACK);
    w_nextDone = (w_nextState == S_DONE);
    w_nextPass = w_nextDone && (w_nextScore == SCORE_W'(DISPLAY_CYCLE));
  end

  // Registered datapath and status outputs, aligned with the state register.
  always_ff @(posedge game_clk or negedge resetn) begin
    if (!resetn) begin
      r_index <= '0;
      r_score <= '0;
      r_guess <= '0;
      r_led   <= '0;
      r_fbCnt <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_index <= w_nextIndex;
      r_score <= w_nextScore;
      r_guess <= w_nextGuess;
      r_led   <= w_nextLed;
      r_fbCnt <= w_nextFbCnt;
      r_busy  <= w_nextBusy;
      r_done  <= w_nextDone;
      r_pass  <= w_nextPass;
    end
  end

  // rn follows the index register directly so q settles a cycle ahead of COMPARE.
  assign bus.rn    = r_index;
  assign bus.led   = r_led;
  assign bus.score = r_score;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.pass  = r_pass;

endmodule

// File: tb/tb_game_check.sv
// tb_game_check
// Self-checking bench for game_check: table-driven rounds, randomized rounds
// against a round-level model, and directed multi-cycle corner sequences.
module tb_game_check;
  import memory_game_pkg::*;

  localparam int DC = 10;
  localparam int FC = 4;

  logic game_clk = 1'b0;
  logic resetn;

  game_check_if ifc();

  logic [9:0] mem [16];

  // Memory model: read data is a pure function of the address.
  always_comb ifc.q = mem[ifc.rn];

  game_check #(
    .DISPLAY_CYCLE   (DC),
    .FEEDBACK_CYCLES (FC)
  ) dut (
    .game_clk (game_clk),
    .resetn   (resetn),
    .bus      (ifc)
  );

  always #5 game_clk = ~game_clk;

  int checkCnt = 0;
  int passCnt  = 0;

  typedef struct {
    logic [9:0] memVal;
    logic [9:0] swVal;
    logic [9:0] expLed;
    logic [3:0] expScore;
  } vec_t;

  vec_t vecs [20];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Presses the key (held for 'hold' cycles), optionally presses again at
  // cycle rePressAt, and records the first nonzero led run while not done.
  task automatic applyStimulus(input logic [9:0] swVal, input int hold, input int rePressAt,
                               output logic [9:0] fbVal, output int fbLen, output int runs);
    bit inRun;
    int limit;
    inRun = 1'b0;
    limit = hold + 16;
    fbVal = '0;
    fbLen = 0;
    runs  = 0;
    @(negedge game_clk);
    ifc.sw          = swVal;
    ifc.confirm_key = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge game_clk);
      if (ifc.led != 10'h000 && !ifc.done) begin
        if (!inRun) begin
          runs++;
          inRun = 1'b1;
          if (runs == 1) fbVal = ifc.led;
        end
        if (runs == 1) fbLen++;
      end else begin
        inRun = 1'b0;
      end
      ifc.confirm_key = !((k < hold) || (rePressAt > 0 && k >= rePressAt && k < rePressAt + 2));
    end
    ifc.confirm_key = 1'b1;
  endtask

  task automatic pulseStart();
    @(negedge game_clk);
    ifc.check_start = 1'b1;
    @(negedge game_clk);
    ifc.check_start = 1'b0;
  endtask

  // One full round; expectations come from the table or from the round model.
  task automatic playRound(input bit useTable, input int base);
    int         expScore;
    logic [9:0] guesses [10];
    logic [9:0] expLed;
    logic [9:0] fbVal;
    int         fbLen;
    int         runs;
    int         hold;
    expScore = 0;
    for (int i = 0; i < DC; i++) begin
      if (useTable) begin
        mem[i]     = vecs[base+i].memVal;
        guesses[i] = vecs[base+i].swVal;
      end else begin
        mem[i]     = 10'($urandom_range(1, 1023));
        guesses[i] = ($urandom_range(0, 1) == 1) ? mem[i] : 10'($urandom_range(0, 1023));
      end
    end
    pulseStart();
    checkOutput("startBusy", 32'(ifc.busy), 32'd1);
    checkOutput("startScore", 32'(ifc.score), 32'd0);
    for (int i = 0; i < DC; i++) begin
      checkOutput("rnIndex", 32'(ifc.rn), 32'(i));
      hold = useTable ? 1 : int'($urandom_range(1, 6));
      applyStimulus(guesses[i], hold, 0, fbVal, fbLen, runs);
      if (useTable) begin
        expLed   = vecs[base+i].expLed;
        expScore = int'(vecs[base+i].expScore);
      end else if (guesses[i] == mem[i]) begin
        expLed   = 10'h3FF;
        expScore = expScore + 1;
      end else begin
        expLed   = mem[i];
      end
      checkOutput("feedbackLed", 32'(fbVal), 32'(expLed));
      checkOutput("feedbackLen", 32'(fbLen), 32'(FC));
      checkOutput("score", 32'(ifc.score), 32'(expScore));
    end
    checkOutput("roundDone", 32'(ifc.done), 32'd1);
    checkOutput("roundPass", 32'(ifc.pass), 32'(expScore == DC));
    checkOutput("roundLed", 32'(ifc.led), 32'((1 << expScore) - 1));
    checkOutput("roundBusy", 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    logic [9:0] fbVal;
    int         fbLen;
    int         runs;
    logic [9:0] m;

    for (int i = 0; i < DC; i++) begin
      m = (i == 9) ? 10'h3FF : (10'h001 << i);
      vecs[i]    = '{m, m, 10'h3FF, 4'(i + 1)};
      vecs[10+i] = '{m, (i == 2) ? 10'h008 : m, (i == 2) ? 10'h004 : 10'h3FF,
                     4'((i < 2) ? i + 1 : i)};
    end
    for (int i = 0; i < 16; i++) mem[i] = 10'h000;

    ifc.check_start = 1'b0;
    ifc.confirm_key = 1'b1;
    ifc.sw          = 10'h000;
    resetn          = 1'b0;
    repeat (3) @(negedge game_clk);
    checkOutput("resetLed", 32'(ifc.led), 32'd0);
    checkOutput("resetScore", 32'(ifc.score), 32'd0);
    checkOutput("resetRn", 32'(ifc.rn), 32'd0);
    checkOutput("resetBusy", 32'(ifc.busy), 32'd0);
    checkOutput("resetDone", 32'(ifc.done), 32'd0);
    checkOutput("resetPass", 32'(ifc.pass), 32'd0);
    resetn = 1'b1;

    // A press before any check_start is ignored.
    applyStimulus(10'h001, 1, 0, fbVal, fbLen, runs);
    checkOutput("idlePressRuns", 32'(runs), 32'd0);
    checkOutput("idlePressBusy", 32'(ifc.busy), 32'd0);

    $display("[TB] table rounds");
    playRound(1'b1, 0);
    playRound(1'b1, 10);

    $display("[TB] random rounds");
    for (int r = 0; r < 3; r++) playRound(1'b0, 0);

    for (int i = 0; i < DC; i++) mem[i] = vecs[i].memVal;

    // Key held low 50 cycles consumes exactly one guess.
    pulseStart();
    applyStimulus(mem[0], 50, 0, fbVal, fbLen, runs);
    checkOutput("holdRuns", 32'(runs), 32'd1);
    checkOutput("holdFeedback", 32'(fbVal), 32'h3FF);
    checkOutput("holdRn", 32'(ifc.rn), 32'd1);
    checkOutput("holdScore", 32'(ifc.score), 32'd1);
    checkOutput("holdBusy", 32'(ifc.busy), 32'd1);

    // Press during FEEDBACK is discarded; next guess needs a fresh press.
    applyStimulus(mem[1], 1, 4, fbVal, fbLen, runs);
    checkOutput("fbPressRuns", 32'(runs), 32'd1);
    checkOutput("fbPressRn", 32'(ifc.rn), 32'd2);
    checkOutput("fbPressLed", 32'(ifc.led), 32'd0);
    applyStimulus(mem[2], 1, 0, fbVal, fbLen, runs);
    checkOutput("freshPressLen", 32'(fbLen), 32'(FC));
    checkOutput("freshPressRn", 32'(ifc.rn), 32'd3);

    // Abort at index 5 with score 4.
    pulseStart();
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 1) ? ~mem[i] : mem[i], 1, 0, fbVal, fbLen, runs);
    end
    checkOutput("preAbortScore", 32'(ifc.score), 32'd4);
    checkOutput("preAbortRn", 32'(ifc.rn), 32'd5);
    pulseStart();
    checkOutput("abortScore", 32'(ifc.score), 32'd0);
    checkOutput("abortRn", 32'(ifc.rn), 32'd0);
    checkOutput("abortBusy", 32'(ifc.busy), 32'd1);
    applyStimulus(mem[0], 1, 0, fbVal, fbLen, runs);
    checkOutput("abortNextLed", 32'(fbVal), 32'h3FF);
    checkOutput("abortNextScore", 32'(ifc.score), 32'd1);

    // Reset asserted while in COMPARE.
    pulseStart();
    @(negedge game_clk);
    ifc.sw          = mem[0];
    ifc.confirm_key = 1'b0;
    repeat (3) @(negedge game_clk);
    #1 resetn = 1'b0;
    ifc.confirm_key = 1'b1;
    #1;
    checkOutput("midResetBusy", 32'(ifc.busy), 32'd0);
    checkOutput("midResetScore", 32'(ifc.score), 32'd0);
    checkOutput("midResetLed", 32'(ifc.led), 32'd0);
    checkOutput("midResetRn", 32'(ifc.rn), 32'd0);
    @(negedge game_clk);
    resetn = 1'b1;
    applyStimulus(mem[0], 1, 0, fbVal, fbLen, runs);
    checkOutput("postResetRuns", 32'(runs), 32'd0);
    checkOutput("postResetBusy", 32'(ifc.busy), 32'd0);
    checkOutput("postResetScore", 32'(ifc.score), 32'd0);
    pulseStart();
    applyStimulus(mem[0], 1, 0, fbVal, fbLen, runs);
    checkOutput("restartLed", 32'(fbVal), 32'h3FF);
    checkOutput("restartScore", 32'(ifc.score), 32'd1);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
